// File: rtl/schoening_solver_pkg.sv
// schoening_solver_pkg: shared types, constants and width helper for the Schoening solver
package schoening_solver_pkg;
    typedef enum logic [1:0] {IDLE, INIT, CHECK, DONE} state_t;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
    function automatic int log2c(input int v);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/schoening_solver_if.sv
// schoening_solver_if: formula load port plus start/done search handshake
interface schoening_solver_if
    import schoening_solver_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 16,
    parameter int K = 3,
    parameter int TRIES = 64
);
    logic                        load_en;
    logic [log2c(M)-1:0]         load_clause;
    logic [log2c(K)-1:0]         load_slot;
    logic [log2c(N+1):0]         load_lit;
    logic                        start;
    logic                        busy;
    logic                        done;
    logic                        sat;
    logic [N-1:0]                solution;
    logic [log2c(TRIES+1)-1:0]   tries_used;
    modport master(output load_en, load_clause, load_slot, load_lit, start,
                   input busy, done, sat, solution, tries_used);
    modport slave(input load_en, load_clause, load_slot, load_lit, start,
                  output busy, done, sat, solution, tries_used);
endinterface

// File: rtl/schoening_solver_unsat_select.sv
// unsat_select: fair pick of one unsatisfied clause via rotate / priority-encode / rotate back
module unsat_select
    import schoening_solver_pkg::*;
#(
    parameter int M = 16
) (
    input  logic [M-1:0]          unsat,
    input  logic [log2c(M)-1:0]   rot,
    output logic [M-1:0]          pick,
    output logic                  none
);
    logic [M-1:0] rl, first;
    always_comb begin
        rl    = M'(({unsat, unsat} << rot) >> M);
        first = rl & (~rl + 1'b1);
        pick  = M'({first, first} >> rot);
        none  = ~|unsat;
    end
endmodule

// File: rtl/schoening_solver.sv
// schoening_solver: loadable CNF store plus Schoening random-walk search engine
module schoening_solver
    import schoening_solver_pkg::*;
#(
    parameter int N = 32,
    parameter int M = 16,
    parameter int K = 3,
    parameter int FLIPS = 96,
    parameter int TRIES = 64,
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input logic clk,
    input logic reset,
    schoening_solver_if.slave bus
);
    localparam int CW = log2c(M);
    localparam int LSW = log2c(K);
    // one spare index bit so an all-ones index always lies beyond N-1
    localparam int VW = log2c(N + 1);
    localparam int LW = VW + 1;
    localparam int TW = log2c(TRIES + 1);
    localparam int FW = log2c(FLIPS + 1);
    localparam logic [LW-1:0] PAD = '1;
    localparam logic [31:0] SEED_NZ = (SEED == 32'd0) ? 32'd1 : SEED;

    state_t            state;
    logic [31:0]       lfsr;
    logic [LW-1:0]     lits [M][K];
    logic [N-1:0]      asg, flip_mask, init_asg;
    logic [FW-1:0]     flip_cnt;
    logic [M-1:0]      unsat, pick;
    logic              none;
    logic [CW-1:0]     raw_c, r_c;
    logic [LSW-1:0]    raw_l, r_l;
    logic [VW-1:0]     chosen;
    logic              loadable;

    function automatic logic lit_true(input logic [LW-1:0] l, input logic [N-1:0] a);
        lit_true = 1'b0;
        for (int i = 0; i < N; i++) if (l[LW-1:1] == VW'(i) && a[i] == l[0]) lit_true = 1'b1;
    endfunction

    assign raw_c = lfsr[CW-1:0];
    assign raw_l = lfsr[CW+LSW-1:CW];
    assign r_c = ({1'b0, raw_c} >= (CW+1)'(M)) ? raw_c - CW'(M) : raw_c;
    assign r_l = ({1'b0, raw_l} >= (LSW+1)'(K)) ? raw_l - LSW'(K) : raw_l;
    assign loadable = (state == IDLE) || (state == DONE);

    always_comb begin
        unsat = '0;
        for (int c = 0; c < M; c++) begin
            unsat[c] = 1'b1;
            for (int s = 0; s < K; s++) if (lit_true(lits[c][s], asg)) unsat[c] = 1'b0;
        end
    end

    unsat_select #(.M(M)) u_sel (.unsat(unsat), .rot(r_c), .pick(pick), .none(none));

    always_comb begin
        chosen = '0;
        flip_mask = '0;
        init_asg = '0;
        for (int c = 0; c < M; c++) if (pick[c]) chosen = lits[c][r_l][LW-1:1];
        for (int i = 0; i < N; i++) begin
            flip_mask[i] = (chosen == VW'(i));
            init_asg[i] = lfsr[i % 32];
        end
    end

    always_ff @(posedge clk or negedge reset)
        if (!reset) lfsr <= SEED_NZ;
        else lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'd0);

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            for (int c = 0; c < M; c++)
                for (int s = 0; s < K; s++) lits[c][s] <= PAD;
        end else if (loadable && bus.load_en && {1'b0, bus.load_clause} < (CW+1)'(M)
                     && {1'b0, bus.load_slot} < (LSW+1)'(K))
            lits[bus.load_clause][bus.load_slot] <= bus.load_lit;

    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            state <= IDLE;
            asg <= '0;
            flip_cnt <= '0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.sat <= 1'b0;
            bus.solution <= '0;
            bus.tries_used <= '0;
        end else case (state)
            IDLE, DONE: if (bus.start) begin
                state <= INIT;
                bus.busy <= 1'b1;
                bus.done <= 1'b0;
                bus.sat <= 1'b0;
                bus.tries_used <= '0;
            end
            INIT: begin
                asg <= init_asg;
                flip_cnt <= FW'(FLIPS);
                bus.tries_used <= bus.tries_used + 1'b1;
                state <= CHECK;
            end
            CHECK: if (none) begin
                state <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.sat <= 1'b1;
                bus.solution <= asg;
            end else if (flip_cnt == '0 && bus.tries_used == TW'(TRIES)) begin
                state <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.sat <= 1'b0;
                bus.solution <= '0;
            end else if (flip_cnt == '0) state <= INIT;
            else begin
                asg <= asg ^ flip_mask;
                flip_cnt <= flip_cnt - 1'b1;
            end
            default: state <= IDLE;
        endcase
endmodule
